// File: rtl/bcd_scan_ctrl_pkg.sv
// Shared definitions for the BCD display controller: FSM encoding, digit
// geometry, seven-segment codes and the double-dabble adjust step.
package bcd_scan_ctrl_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_CONV = 1'b1;

  localparam int NUM_DIGITS = 3;
  localparam int CONV_STEPS = 8;

  // Segment order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
  } digits_t;

  function automatic logic [11:0] dabbleAdjust(input logic [11:0] acc);
    logic [11:0] res;
    res = acc;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (acc[4*n +: 4] >= 4'd5) res[4*n +: 4] = acc[4*n +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD-to-seven-segment encoder; non-decimal nibbles go dark.
module seg7_encode
  import bcd_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Binary-to-BCD converter (one double-dabble step per cycle) feeding a
// free-running three-digit multiplexed seven-segment scanner.
module bcd_scan_ctrl
  import bcd_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bin_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [2:0] dig_sel
);

  localparam logic [2:0]  LAST_STEP = 3'(CONV_STEPS - 1);
  localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);

  logic        state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  step_q, step_d;
  digits_t     shadow_q, shadow_d;
  logic        done_q, done_d;
  logic [15:0] divCnt_q, divCnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [2:0]  digSel_q, digSel_d;

  logic [11:0] accAdj;
  logic [3:0]  digitMux;
  logic [6:0]  segCode;
  logic        blank;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    step_d   = step_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    accAdj   = dabbleAdjust(acc_q);
    case (state_q)
      STATE_IDLE: begin
        if (load) begin
          state_d = STATE_CONV;
          shift_d = bin_in;
          acc_d   = '0;
          step_d  = '0;
        end
      end
      default: begin
        acc_d   = {accAdj[10:0], shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
        step_d  = step_q + 3'd1;
        // The eighth shift produces the final BCD value; commit it directly
        if (step_q == LAST_STEP) begin
          state_d  = STATE_IDLE;
          shadow_d = digits_t'(acc_d);
          done_d   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    divCnt_d = divCnt_q + 16'd1;
    idx_d    = idx_q;
    if (divCnt_q == DIV_LAST) begin
      divCnt_d = '0;
      idx_d    = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    digitMux = shadow_q.units;
    digSel_d = 3'b001;
    blank    = 1'b0;
    case (idx_q)
      2'd1: begin
        digitMux = shadow_q.tens;
        digSel_d = 3'b010;
        blank    = BLANK_LZ && (shadow_q.tens == 4'd0) && (shadow_q.hund == 4'd0);
      end
      2'd2: begin
        digitMux = shadow_q.hund;
        digSel_d = 3'b100;
        blank    = BLANK_LZ && (shadow_q.hund == 4'd0);
      end
      default: ;
    endcase
    seg_d = blank ? SEG_OFF : segCode;
  end

  seg7_encode uEncode (
    .bcd_i (digitMux),
    .seg_o (segCode)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STATE_IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      divCnt_q <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      digSel_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      divCnt_q <= divCnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      digSel_q <= digSel_d;
    end
  end

  assign busy    = (state_q == STATE_CONV);
  assign done    = done_q;
  assign seg     = seg_q;
  assign dig_sel = digSel_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed self-checking bench: three instances cover the default scanner,
// leading-zero blanking and the single-cycle scan divider.
module tb_bcd_scan_ctrl;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] SOFF = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] binMain, binBlank, binFast;
  logic loadMain, loadBlank, loadFast;
  logic busyMain, busyBlank, busyFast;
  logic doneMain, doneBlank, doneFast;
  logic [6:0] segMain, segBlank, segFast;
  logic [2:0] digMain, digBlank, digFast;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dutMain (
    .clk(clk), .rst_n(rst_n), .bin_in(binMain), .load(loadMain),
    .busy(busyMain), .done(doneMain), .seg(segMain), .dig_sel(digMain));

  bcd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dutBlank (
    .clk(clk), .rst_n(rst_n), .bin_in(binBlank), .load(loadBlank),
    .busy(busyBlank), .done(doneBlank), .seg(segBlank), .dig_sel(digBlank));

  bcd_scan_ctrl #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dutFast (
    .clk(clk), .rst_n(rst_n), .bin_in(binFast), .load(loadFast),
    .busy(busyFast), .done(doneFast), .seg(segFast), .dig_sel(digFast));

  function automatic logic [2:0] curDig(input int sel);
    return (sel == 0) ? digMain : (sel == 1) ? digBlank : digFast;
  endfunction

  function automatic logic [6:0] curSeg(input int sel);
    return (sel == 0) ? segMain : (sel == 1) ? segBlank : segFast;
  endfunction

  function automatic logic curDone(input int sel);
    return (sel == 0) ? doneMain : (sel == 1) ? doneBlank : doneFast;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  // Drives one load pulse (or leaves it held); returns at the first busy cycle
  task automatic applyStimulus(input int sel, input logic [7:0] value, input bit hold);
    @(negedge clk);
    case (sel)
      0: begin binMain = value;  loadMain = 1'b1;  end
      1: begin binBlank = value; loadBlank = 1'b1; end
      default: begin binFast = value; loadFast = 1'b1; end
    endcase
    @(negedge clk);
    if (!hold) begin
      loadMain  = 1'b0;
      loadBlank = 1'b0;
      if (sel == 2) loadFast = 1'b0;
    end
  endtask

  task automatic checkDigit(input int sel, input logic [2:0] target,
                            input logic [6:0] expSeg, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (curDig(sel) !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_dig"}, 16'(curDig(sel)), 16'(target));
    checkOutput({tag, "_seg"}, 16'(curSeg(sel)), 16'(expSeg));
  endtask

  task automatic waitDone(input int sel, input string tag);
    int n;
    n = 0;
    while (curDone(sel) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 16'(curDone(sel)), 16'd1);
  endtask

  initial begin
    int doneCnt;
    int busyCnt;
    int n;
    logic [2:0] expDig;

    rst_n = 1'b0;
    binMain = '0; binBlank = '0; binFast = '0;
    loadMain = 1'b0; loadBlank = 1'b0; loadFast = 1'b0;

    @(negedge clk);
    checkOutput("rst_seg", 16'(segMain), 16'(SOFF));
    checkOutput("rst_dig", 16'(digMain), 16'd0);
    checkOutput("rst_busy", 16'(busyMain), 16'd0);
    checkOutput("rst_done", 16'(doneMain), 16'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      case (((k - 1) / 4) % 3)
        0: expDig = 3'b001;
        1: expDig = 3'b010;
        default: expDig = 3'b100;
      endcase
      checkOutput($sformatf("scan_dig_%0d", k), 16'(digMain), 16'(expDig));
      checkOutput($sformatf("scan_seg_%0d", k), 16'(segMain), 16'(S0));
    end

    // 255 -> 2,5,5 with busy for exactly eight cycles then a done pulse
    applyStimulus(0, 8'd255, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("c255_busy_%0d", i), 16'(busyMain), 16'd1);
      checkOutput($sformatf("c255_done_%0d", i), 16'(doneMain), 16'd0);
      @(negedge clk);
    end
    checkOutput("c255_busy_end", 16'(busyMain), 16'd0);
    checkOutput("c255_done_pulse", 16'(doneMain), 16'd1);
    @(negedge clk);
    checkOutput("c255_done_low", 16'(doneMain), 16'd0);
    checkDigit(0, 3'b001, S5, "c255_units");
    checkDigit(0, 3'b010, S5, "c255_tens");
    checkDigit(0, 3'b100, S2, "c255_hund");

    // 100 with a stray load of 42 on busy cycle 3
    applyStimulus(0, 8'd100, 1'b0);
    @(negedge clk);
    @(negedge clk);
    binMain = 8'd42;
    loadMain = 1'b1;
    @(negedge clk);
    loadMain = 1'b0;
    doneCnt = 0;
    busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busyMain === 1'b1) busyCnt++;
      if (doneMain === 1'b1) doneCnt++;
      @(negedge clk);
    end
    checkOutput("c100_busy_cycles", 16'(busyCnt), 16'd5);
    checkOutput("c100_done_count", 16'(doneCnt), 16'd1);
    checkDigit(0, 3'b001, S0, "c100_units");
    checkDigit(0, 3'b010, S0, "c100_tens");
    checkDigit(0, 3'b100, S1, "c100_hund");

    // Leading-zero blanking
    applyStimulus(1, 8'd7, 1'b0);
    waitDone(1, "b7_done");
    checkDigit(1, 3'b001, S7, "b7_units");
    checkDigit(1, 3'b010, SOFF, "b7_tens");
    checkDigit(1, 3'b100, SOFF, "b7_hund");
    applyStimulus(1, 8'd205, 1'b0);
    waitDone(1, "b205_done");
    checkDigit(1, 3'b001, S5, "b205_units");
    checkDigit(1, 3'b010, S0, "b205_tens");
    checkDigit(1, 3'b100, S2, "b205_hund");

    // Reset during busy cycle 5 aborts without commit
    applyStimulus(0, 8'd199, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 16'(busyMain), 16'd0);
    checkOutput("abort_done", 16'(doneMain), 16'd0);
    checkOutput("abort_dig", 16'(digMain), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_first_dig", 16'(digMain), 16'b001);
    checkOutput("abort_first_seg", 16'(segMain), 16'(S0));
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (doneMain === 1'b1) doneCnt++;
    end
    checkOutput("abort_no_done", 16'(doneCnt), 16'd0);
    checkDigit(0, 3'b100, S0, "abort_hund");
    checkDigit(0, 3'b010, S0, "abort_tens");

    // SCAN_DIV=1 with load held high
    checkDigit(2, 3'b001, S0, "fast_sync");
    @(negedge clk);
    checkOutput("fast_rot_1", 16'(digFast), 16'b010);
    @(negedge clk);
    checkOutput("fast_rot_2", 16'(digFast), 16'b100);
    @(negedge clk);
    checkOutput("fast_rot_3", 16'(digFast), 16'b001);
    applyStimulus(2, 8'd50, 1'b1);
    waitDone(2, "fast_first_done");
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("fast_idle_%0d", p), 16'(busyFast), 16'd0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (doneFast !== 1'b1 && n < 30);
      checkOutput($sformatf("fast_period_%0d", p), 16'(n), 16'd9);
    end
    loadFast = 1'b0;
    checkDigit(2, 3'b010, S5, "fast_tens");
    checkDigit(2, 3'b001, S0, "fast_units");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
